midori_inv_shuffle_stream: RTL and testbench

//  Cell-serial inverse ShuffleCell for the Midori decryption datapath.
//  - Accepts one 128-bit state as 16 cells, cell 0 first, over a valid/ready stream.
//  - Emits the same block reordered by the inverse permutation, so out(ShuffleCell(S)) = S.
//  - Ping-pong buffered: one block is filled while the previous one drains.

---
 rtl/midori_pkg.sv | 23 ++
 rtl/midori_cell_bank.sv | 26 ++
 rtl/midori_inv_shuffle_stream.sv | 102 ++++++++++
 tb/tb_midori_inv_shuffle_stream.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midori_pkg.sv
// Shared constants and types for the Midori cell-serial datapath.
// MIDORI_SHUF_P is the forward ShuffleCell; MIDORI_SHUF_INV_P is its inverse.
package midori_pkg;

  localparam int unsigned MIDORI_NCELLS = 16;

  typedef logic [3:0] cell_idx_t;
  typedef cell_idx_t [MIDORI_NCELLS-1:0] cell_tbl_t;

  localparam cell_idx_t MIDORI_LAST_IDX = 4'(MIDORI_NCELLS - 1);

  // Entry 0 sits in the least significant nibble.
  localparam cell_tbl_t MIDORI_SHUF_P = {
    4'd8, 4'd2, 4'd13, 4'd7, 4'd6, 4'd12, 4'd3, 4'd9,
    4'd1, 4'd11, 4'd4, 4'd14, 4'd15, 4'd5, 4'd10, 4'd0
  };

  localparam cell_tbl_t MIDORI_SHUF_INV_P = {
    4'd3, 4'd4, 4'd13, 4'd10, 4'd6, 4'd1, 4'd8, 4'd15,
    4'd12, 4'd11, 4'd2, 4'd5, 4'd9, 4'd14, 4'd7, 4'd0
  };

endpackage

// File: rtl/midori_cell_bank.sv
// One 16-cell state buffer: single write port, single combinational read port.
module midori_cell_bank
  import midori_pkg::*;
#(
  parameter int unsigned CELL_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  cell_idx_t         wr_idx,
  input  logic [CELL_W-1:0] wr_data,
  input  cell_idx_t         rd_idx,
  output logic [CELL_W-1:0] rd_data
);

  // Contents are intentionally not reset; the full flag qualifies them.
  logic [CELL_W-1:0] mem [MIDORI_NCELLS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/midori_inv_shuffle_stream.sv
// Ping-pong buffered cell-serial inverse ShuffleCell stream.
// Define MIDORI_SHUFFLE_DIR_EN to add a per-block `dir` input selecting forward P.
module midori_inv_shuffle_stream
  import midori_pkg::*;
#(
  parameter int unsigned CELL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CELL_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CELL_W-1:0] out_data,
`ifdef MIDORI_SHUFFLE_DIR_EN
  input  logic              dir,
`endif
  output logic              out_last
);

  logic [1:0]  full_q, full_d;
  logic        wr_bank_q, rd_bank_q;
  cell_idx_t   wr_idx_q, rd_idx_q;
  cell_idx_t   rd_perm;
  logic        wr_fire, rd_fire;
  logic [CELL_W-1:0] bank_rd_data [2];

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_idx_q == MIDORI_LAST_IDX);
  assign out_data  = bank_rd_data[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

`ifdef MIDORI_SHUFFLE_DIR_EN
  logic [1:0] dir_q;
  assign rd_perm = dir_q[rd_bank_q] ? MIDORI_SHUF_P[rd_idx_q] : MIDORI_SHUF_INV_P[rd_idx_q];
`else
  assign rd_perm = MIDORI_SHUF_INV_P[rd_idx_q];
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    midori_cell_bank #(
      .CELL_W (CELL_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank_q == 1'(b))),
      .wr_idx  (wr_idx_q),
      .wr_data (in_data),
      .rd_idx  (rd_perm),
      .rd_data (bank_rd_data[b])
    );
  end

  // Write completion and read completion always target different banks.
  always_comb begin
    full_d = full_q;
    if (wr_fire && (wr_idx_q == MIDORI_LAST_IDX)) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (rd_fire && (rd_idx_q == MIDORI_LAST_IDX)) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        if (wr_idx_q == MIDORI_LAST_IDX) begin
          wr_bank_q <= ~wr_bank_q;
        end
      end
      if (rd_fire) begin
        rd_idx_q <= rd_idx_q + 1'b1;
        if (rd_idx_q == MIDORI_LAST_IDX) begin
          rd_bank_q <= ~rd_bank_q;
        end
      end
    end
  end

`ifdef MIDORI_SHUFFLE_DIR_EN
  // Direction is captured with the first cell and follows its bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= '0;
    end else if (wr_fire && (wr_idx_q == '0)) begin
      dir_q[wr_bank_q] <= dir;
    end
  end
`endif

endmodule

// File: tb/tb_midori_inv_shuffle_stream.sv
// Scoreboard bench for midori_inv_shuffle_stream with a round-trip reference model.
module tb_midori_inv_shuffle_stream;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_data;
  logic          out_last;
`ifdef MIDORI_SHUFFLE_DIR_EN
  logic          dir = 1'b0;
`endif

  midori_inv_shuffle_stream #(
    .CELL_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MIDORI_SHUFFLE_DIR_EN
    .dir       (dir),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errs = 0;
  logic [CW:0] exp_q [$];     // {last, data}
  int in_cycles [$];
  int out_cycles [$];
  logic [CW-1:0] blk [16];
  bit rand_ready = 0;

  // Forward ShuffleCell and the literal expectation of the first directed test.
  int fwd_p [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
  logic [CW-1:0] t1_exp [16] = '{8'h00, 8'h07, 8'h0E, 8'h09, 8'h05, 8'h02, 8'h0B, 8'h0C,
                                 8'h0F, 8'h08, 8'h01, 8'h06, 8'h0A, 8'h0D, 8'h04, 8'h03};
  logic [CW-1:0] t6_exp [16] = '{8'h00, 8'h0A, 8'h05, 8'h0F, 8'h0E, 8'h04, 8'h0B, 8'h01,
                                 8'h09, 8'h03, 8'h0C, 8'h06, 8'h07, 8'h0D, 8'h02, 8'h08};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a transfer seen at the falling edge completes at the next rising edge.
  initial begin
    logic [CW:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        out_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out: got 0x%0h with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_cell", {out_last, out_data}, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the cell was taken.
  task automatic send_cell(input logic [CW-1:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        in_cycles.push_back(cyc);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: in_ready stuck at %0b, needed 1", in_ready);
    end
  endtask

  task automatic send_blk();
    for (int k = 0; k < 16; k++) send_cell(blk[k]);
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [CW-1:0] e [16]);
    for (int j = 0; j < 16; j++) exp_q.push_back({(j == 15), e[j]});
  endtask

  // Builds blk = ShuffleCell(S) for random S and queues S as the expected output.
  task automatic make_roundtrip();
    logic [CW-1:0] s [16];
    for (int j = 0; j < 16; j++) s[j] = CW'($urandom);
    for (int k = 0; k < 16; k++) blk[k] = s[fwd_p[k]];
    push_exp(s);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [CW-1:0] held_data;
    int n;
    int rel_cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    rst = 1'b0;

    // Directed identity block.
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) blk[k] = CW'(k);
    push_exp(t1_exp);
    send_blk();
    drain("t1_drain");

    // Random round trips with random gaps and backpressure.
    rand_ready = 1;
    for (int b = 0; b < 1000; b++) begin
      make_roundtrip();
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send_cell(blk[k]);
      end
      in_valid = 1'b0;
    end
    drain("t2_drain");
    rand_ready = 0;
    @(posedge clk);
    #1;

    // Backpressure: two blocks fill both banks, third must wait.
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      make_roundtrip();
      send_blk();
    end
    @(negedge clk);
    check("t3_in_ready_full", in_ready, 0);
    check("t3_out_valid_held", out_valid, 1);
    held_data = out_data;
    repeat (4) @(negedge clk);
    check("t3_out_data_stable", out_data, held_data);
    check("t3_in_ready_still0", in_ready, 0);
    @(posedge clk);
    #1;
    make_roundtrip();
    rel_cyc = 0;
    in_cycles.delete();
    fork
      send_blk();
      begin
        repeat (3) @(posedge clk);
        #1;
        rel_cyc = cyc;
        out_ready = 1'b1;
      end
    join
    check("t3_blk3_after_release", in_cycles[0] >= rel_cyc, 1);
    drain("t3_drain");

    // Continuous streaming: 4 blocks, both sides always ready.
    in_cycles.delete();
    out_cycles.delete();
    for (int b = 0; b < 4; b++) begin
      make_roundtrip();
      for (int k = 0; k < 16; k++) send_cell(blk[k]);
    end
    in_valid = 1'b0;
    drain("t4_drain");
    check("t4_first_latency", out_cycles[0] - in_cycles[15], 1);
    check("t4_in_span", in_cycles[63] - in_cycles[0], 63);
    check("t4_out_span", out_cycles[63] - out_cycles[0], 63);
    check("t4_out_count", out_cycles.size(), 64);

    // Reset after 7 cells in and 5 cells out.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) blk[k] = CW'(k);
    for (int j = 0; j < 5; j++) exp_q.push_back({1'b0, t1_exp[j]});
    send_blk();
    for (int k = 0; k < 7; k++) send_cell(CW'($urandom));
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 100 && n < 5; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      @(posedge clk);
      #1;
      if (n == 5) out_ready = 1'b0;
    end
    check("t5_five_out", n, 5);
    rst = 1'b1;
    #1;
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_last", out_last, 0);
    check("t5_exp_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    make_roundtrip();
    send_blk();
    drain("t5_drain");

`ifdef MIDORI_SHUFFLE_DIR_EN
    // Per-block direction: forward then inverse.
    for (int k = 0; k < 16; k++) blk[k] = CW'(k);
    push_exp(t6_exp);
    push_exp(t1_exp);
    out_ready = 1'b0;
    dir = 1'b1;
    send_cell(blk[0]);
    dir = 1'b0;
    for (int k = 1; k < 16; k++) send_cell(blk[k]);
    send_blk();
    out_ready = 1'b1;
    drain("t6_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
